ref_level_acc: RTL and testbench
================================

Name: ref_level_acc

Overview:
- Downstream consumer of the maximal-length LFSR symbol source's periodic cycle marker and of the receiver's decision-input samples.
- Accumulates |sample| over exactly one LFSR period, framed by the cycle marker, and publishes mean absolute value and 4-ASK reference level (a, where levels are ±a, ±3a) to the slicer once per period.
- Runs at symbol rate via clk_en.

Parameters:
- DATA_W, 18, width of signed sample_in (two's complement)
- PERIOD_LOG2, `LFSR_LEN, log2 of period length; period is 2^PERIOD_LOG2-1 symbols, divide is a right shift by PERIOD_LOG2
- ACC_W, DATA_W+PERIOD_LOG2, accumulator width (derived; not to be overridden)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  symbol strobe; all state advances only when high, except LATCH
- cycle_start  in  1  period marker (LFSR cycle_out_periodic); sampled only when clk_en=1
- sample_in  in  DATA_W  signed decision-input sample
- mean_abs  out  DATA_W  unsigned mean |sample| of last complete period
- ref_level  out  DATA_W  unsigned reference level a = mean_abs/2
- ref_valid  out  1  one-clk pulse when mean_abs/ref_level update
- ref_locked  out  1  high from first update until reset
- period_err  out  1  sticky: a period closed with count != 2^PERIOD_LOG2-1
- avg_power  out  2*DATA_W  mean sample^2 (optional feature, else 0)

Behaviour:
- Reset (async): all outputs 0, acc=0, cnt=0, state IDLE.
- abs: |sample_in| as DATA_W-bit unsigned; most negative value -2^(DATA_W-1) maps exactly to 2^(DATA_W-1).
- States: IDLE, ACCUM, LATCH.
- IDLE: on clk_en && cycle_start go to ACCUM, acc<=abs, cnt<=1. Samples before the first marker are discarded.
- ACCUM, clk_en && !cycle_start: acc<=acc+abs, saturating at all-ones; cnt<=cnt+1, saturating at all-ones.
- ACCUM, clk_en && cycle_start (closing strobe): snap<=acc, snap_cnt<=cnt, acc<=abs, cnt<=1, go to LATCH. The closing-strobe sample belongs to the new period.
- LATCH: executes on the next clk edge regardless of clk_en, then returns to ACCUM. Accumulation of a clk_en in that same cycle proceeds normally.
  - mean_abs<=snap>>PERIOD_LOG2 (truncate, low DATA_W bits)
  - ref_level<=snap>>(PERIOD_LOG2+1)
  - ref_valid<=1 for exactly one clk
  - ref_locked<=1
  - if snap_cnt != 2^PERIOD_LOG2-1: period_err<=1
- Latency: outputs are visible 2 clk edges after the closing-strobe edge.
- clk_en low in ACCUM: acc and cnt hold, state holds.
- Short or long periods still update outputs from the truncated or saturated accumulation and set period_err; period_err is cleared only by reset.
- Reset mid-period: all partial accumulation lost; returns to IDLE; requires a new marker before accumulating.

Optional Feature:
- Macro REF_LEVEL_POWER_EN.
- Defined: parallel pwr_acc (2*DATA_W+PERIOD_LOG2 bits, saturating) accumulates sample_in^2 under the same framing. In LATCH, avg_power<=pwr_snap>>PERIOD_LOG2.
- Undefined: no multiplier or power accumulator; avg_power is tied to 0. The port list is unchanged.

Decomposition:
- `LFSR_LEN and any shared sample width macro come from defines.vh. State encodings are localparams in the block.
- One natural sub-module: sat_accumulator (parameterized width; clear-load/add/hold with saturation). Instantiated for acc, cnt and, when REF_LEVEL_POWER_EN is defined, pwr_acc.

Test Plan:
All scenarios use PERIOD_LOG2=4 (period 15), DATA_W=18, and clk_en every 2nd clk.
1. Constant +1000, markers every 15 strobes -> after 2nd marker: mean_abs=937, ref_level=468, ref_valid one clk, ref_locked=1, period_err=0; with REF_LEVEL_POWER_EN, avg_power=937500.
2. Alternating ±3000 -> mean_abs=2812, ref_level=1406. Samples preceding the first marker are ignored.
3. Constant -131072 -> mean_abs=122880, ref_level=61440; no overflow.
4. Markers 10 strobes apart, constant +1000 -> mean_abs=625, period_err=1 and stays 1 after later correct periods.
5. Reset asserted mid-ACCUM, then 15-strobe periods -> outputs 0 until two markers seen post-reset; no update from the pre-reset partial sum.
6. clk_en held low 20 clks mid-period, cycle_start pulsed while clk_en low -> no accumulation, no closing. Result equals scenario 1.

Source files
------------

// File: rtl/ref_level_acc_pkg.sv
// Shared types and defaults for the 4-ASK reference-level accumulator.
// LFSR_LEN sets the LFSR period exponent; it defaults to 4 when not defined.
`ifndef LFSR_LEN
`define LFSR_LEN 4
`endif

package ref_level_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W      = 18;
  localparam int DEFAULT_PERIOD_LOG2 = `LFSR_LEN;

endpackage

// File: rtl/ref_level_acc_sat_accumulator.sv
// Unsigned accumulator with load, saturating add and hold.
// Load has priority over add. The input is zero-extended or truncated to W bits.
module ref_level_acc_sat_accumulator #(
  parameter int W    = 8,
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            add,
  input  logic [IN_W-1:0] in_val,
  output logic [W-1:0]    q
);

  logic [W:0]   sum_s;
  logic [W-1:0] q_r;

  // widened sum so the carry out flags saturation
  always_comb begin
    sum_s = {1'b0, q_r} + (W+1)'(in_val);
  end

  // accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= W'(in_val);
    end else if (add) begin
      q_r <= sum_s[W] ? {W{1'b1}} : sum_s[W-1:0];
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/ref_level_acc.sv
// Per-LFSR-period mean |sample| and 4-ASK reference level.
// Optional REF_LEVEL_POWER_EN adds a mean sample^2 output.
`ifndef LFSR_LEN
`define LFSR_LEN 4
`endif

module ref_level_acc
  import ref_level_acc_pkg::*;
#(
  parameter int DATA_W      = 18,
  parameter int PERIOD_LOG2 = `LFSR_LEN,
  parameter int ACC_W       = DATA_W + PERIOD_LOG2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     cycle_start,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0]        mean_abs,
  output logic [DATA_W-1:0]        ref_level,
  output logic                     ref_valid,
  output logic                     ref_locked,
  output logic                     period_err,
  output logic [2*DATA_W-1:0]      avg_power
);

  // one spare bit lets over-long periods register as a count mismatch
  localparam int CNT_W = PERIOD_LOG2 + 1;
  localparam logic [CNT_W-1:0] PERIOD_LEN = CNT_W'((1 << PERIOD_LOG2) - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [DATA_W-1:0]  abs_s;
  logic               open_s;
  logic               close_s;
  logic               add_s;
  logic [ACC_W-1:0]   acc_s;
  logic [ACC_W-1:0]   snap_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [CNT_W-1:0]   snap_cnt_r;

  // magnitude and framing strobes
  always_comb begin
    if (sample_in[DATA_W-1]) begin
      abs_s = DATA_W'(~sample_in + DATA_W'(1));
    end else begin
      abs_s = DATA_W'(sample_in);
    end
    open_s  = clk_en & cycle_start;
    close_s = open_s & (state_r != ST_IDLE);
    add_s   = clk_en & ~cycle_start & (state_r != ST_IDLE);
  end

  ref_level_acc_sat_accumulator #(.W(ACC_W), .IN_W(DATA_W)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .load   (open_s),
    .add    (add_s),
    .in_val (abs_s),
    .q      (acc_s)
  );

  ref_level_acc_sat_accumulator #(.W(CNT_W), .IN_W(1)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (open_s),
    .add    (add_s),
    .in_val (1'b1),
    .q      (cnt_s)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; LATCH runs for one clk whatever clk_en does
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = open_s  ? ST_ACCUM : ST_IDLE;
      ST_ACCUM: state_nxt_s = close_s ? ST_LATCH : ST_ACCUM;
      ST_LATCH: state_nxt_s = close_s ? ST_LATCH : ST_ACCUM;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // snapshot of the closing period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_r     <= '0;
      snap_cnt_r <= '0;
    end else if (close_s) begin
      snap_r     <= acc_s;
      snap_cnt_r <= cnt_s;
    end else begin
      snap_r     <= snap_r;
      snap_cnt_r <= snap_cnt_r;
    end
  end

  // published results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mean_abs   <= '0;
      ref_level  <= '0;
      ref_valid  <= 1'b0;
      ref_locked <= 1'b0;
      period_err <= 1'b0;
    end else if (state_r == ST_LATCH) begin
      mean_abs   <= DATA_W'(snap_r >> PERIOD_LOG2);
      ref_level  <= DATA_W'(snap_r >> (PERIOD_LOG2 + 1));
      ref_valid  <= 1'b1;
      ref_locked <= 1'b1;
      period_err <= period_err | (snap_cnt_r != PERIOD_LEN);
    end else begin
      mean_abs   <= mean_abs;
      ref_level  <= ref_level;
      ref_valid  <= 1'b0;
      ref_locked <= ref_locked;
      period_err <= period_err;
    end
  end

`ifdef REF_LEVEL_POWER_EN
  localparam int PWR_W = 2*DATA_W + PERIOD_LOG2;

  logic signed [2*DATA_W-1:0] sq_s;
  logic [PWR_W-1:0]           pwr_s;
  logic [PWR_W-1:0]           pwr_snap_r;

  // square is never negative, so it feeds the unsigned accumulator directly
  always_comb begin
    sq_s = sample_in * sample_in;
  end

  ref_level_acc_sat_accumulator #(.W(PWR_W), .IN_W(2*DATA_W)) u_pwr (
    .clk    (clk),
    .reset  (reset),
    .load   (open_s),
    .add    (add_s),
    .in_val (sq_s),
    .q      (pwr_s)
  );

  // power snapshot and published mean power
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwr_snap_r <= '0;
      avg_power  <= '0;
    end else begin
      pwr_snap_r <= close_s ? pwr_s : pwr_snap_r;
      if (state_r == ST_LATCH) begin
        avg_power <= (2*DATA_W)'(pwr_snap_r >> PERIOD_LOG2);
      end else begin
        avg_power <= avg_power;
      end
    end
  end
`else
  assign avg_power = '0;
`endif

endmodule

// File: tb/tb_ref_level_acc.sv
// Randomized self-checking bench for ref_level_acc (period 15, clk_en every 2nd clk).
// Expected values come from a per-strobe arithmetic model of one LFSR period.
module tb_ref_level_acc;

  localparam int DATA_W = 18;
  localparam int P      = 4;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  logic cycle_start;
  logic signed [DATA_W-1:0] sample_in;
  logic [DATA_W-1:0]   mean_abs;
  logic [DATA_W-1:0]   ref_level;
  logic                ref_valid;
  logic                ref_locked;
  logic                period_err;
  logic [2*DATA_W-1:0] avg_power;

  int total = 0;
  int bad   = 0;
  int alt_k = 0;

  bit     m_started;
  longint m_sum;
  longint m_pwr;
  int     m_cnt;
  logic [DATA_W-1:0]   exp_mean;
  logic [DATA_W-1:0]   exp_ref;
  logic                exp_valid;
  logic                exp_locked;
  logic                exp_err;
  logic [2*DATA_W-1:0] exp_pwr;

  ref_level_acc #(.DATA_W(DATA_W), .PERIOD_LOG2(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .cycle_start (cycle_start),
    .sample_in   (sample_in),
    .mean_abs    (mean_abs),
    .ref_level   (ref_level),
    .ref_valid   (ref_valid),
    .ref_locked  (ref_locked),
    .period_err  (period_err),
    .avg_power   (avg_power)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_started  = 1'b0;
    m_sum      = 0;
    m_pwr      = 0;
    m_cnt      = 0;
    exp_mean   = '0;
    exp_ref    = '0;
    exp_valid  = 1'b0;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
    exp_pwr    = '0;
  endfunction

  // one accepted symbol: what the published outputs should be after the latch edge
  function automatic void model_step(input logic cs, input logic signed [DATA_W-1:0] s);
    longint sv;
    longint a;
    sv = s;
    a  = (sv < 0) ? -sv : sv;
    exp_valid = 1'b0;
    if (cs) begin
      if (m_started) begin
        exp_mean   = DATA_W'(m_sum / 16);
        exp_ref    = DATA_W'(m_sum / 32);
        exp_valid  = 1'b1;
        exp_locked = 1'b1;
        if (m_cnt != 15) exp_err = 1'b1;
`ifdef REF_LEVEL_POWER_EN
        exp_pwr = (2*DATA_W)'(m_pwr / 16);
`endif
      end
      m_started = 1'b1;
      m_sum = a;
      m_pwr = sv * sv;
      m_cnt = 1;
    end else if (m_started) begin
      m_sum = m_sum + a;
      if (m_sum > (longint'(1) << 22) - 1) m_sum = (longint'(1) << 22) - 1;
      m_pwr = m_pwr + sv * sv;
      if (m_pwr > (longint'(1) << 40) - 1) m_pwr = (longint'(1) << 40) - 1;
      m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    clk_en = 1'b0; cycle_start = 1'b0; sample_in = '0;
    reset = 1'b1;
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // one symbol strobe followed by one clk with clk_en low; returns 1 after the second edge
  task automatic strobe(input logic cs, input logic signed [DATA_W-1:0] s);
    @(negedge clk);
    clk_en = 1'b1; cycle_start = cs; sample_in = s;
    model_step(cs, s);
    @(negedge clk);
    clk_en = 1'b0; cycle_start = 1'b0; sample_in = DATA_W'($urandom);
    @(posedge clk);
    #1;
  endtask

  // n strobes (first optionally a marker); mode 0 const, 1 alternating, 2 random
  task automatic run_strobes(input int n, input bit first_marker, input int mode, input int val);
    logic signed [DATA_W-1:0] s;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       s = DATA_W'(val);
        1:       s = (alt_k % 2 == 1) ? DATA_W'(-val) : DATA_W'(val);
        default: s = DATA_W'($urandom);
      endcase
      alt_k++;
      strobe(first_marker && (i == 0), s);
      total++;
      if (ref_valid !== exp_valid) begin
        bad++; $display("FAIL valid: got %b want %b", ref_valid, exp_valid);
      end
      total++;
      if (mean_abs !== exp_mean || ref_level !== exp_ref) begin
        bad++; $display("FAIL level: mean %0d/%0d ref %0d/%0d", mean_abs, exp_mean, ref_level, exp_ref);
      end
      total++;
      if (ref_locked !== exp_locked || period_err !== exp_err) begin
        bad++; $display("FAIL flags: locked %b/%b err %b/%b", ref_locked, exp_locked, period_err, exp_err);
      end
      total++;
      if (avg_power !== exp_pwr) begin
        bad++; $display("FAIL power: got %0d want %0d", avg_power, exp_pwr);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b0; cycle_start = 1'b0; sample_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (mean_abs !== 18'd0 || ref_level !== 18'd0) begin
      bad++; $display("FAIL reset_levels: mean %0d ref %0d want 0", mean_abs, ref_level);
    end
    total++;
    if (ref_valid !== 1'b0 || ref_locked !== 1'b0 || period_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags: v%b l%b e%b want 000", ref_valid, ref_locked, period_err);
    end
    total++;
    if (avg_power !== 36'd0) begin
      bad++; $display("FAIL reset_power: got %0d want 0", avg_power);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_const_pos();
    do_reset();
    run_strobes(3, 1'b0, 2, 0);
    run_strobes(15, 1'b1, 0, 1000);
    run_strobes(15, 1'b1, 0, 1000);
    run_strobes(1, 1'b1, 0, 1000);
    total++;
    if (mean_abs !== 18'd937 || ref_level !== 18'd468 || ref_valid !== 1'b1) begin
      bad++; $display("FAIL const_pos: mean %0d ref %0d valid %b want 937 468 1", mean_abs, ref_level, ref_valid);
    end
    total++;
    if (ref_locked !== 1'b1 || period_err !== 1'b0) begin
      bad++; $display("FAIL const_pos_flags: locked %b err %b want 1 0", ref_locked, period_err);
    end
`ifdef REF_LEVEL_POWER_EN
    total++;
    if (avg_power !== 36'd937500) begin
      bad++; $display("FAIL const_pos_power: got %0d want 937500", avg_power);
    end
`endif
    run_strobes(1, 1'b0, 0, 1000);
    total++;
    if (ref_valid !== 1'b0) begin
      bad++; $display("FAIL valid_pulse: got %b want 0", ref_valid);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    run_strobes(6, 1'b0, 2, 0);
    alt_k = 0;
    run_strobes(15, 1'b1, 1, 3000);
    alt_k = 0;
    run_strobes(15, 1'b1, 1, 3000);
    total++;
    if (mean_abs !== 18'd2812 || ref_level !== 18'd1406) begin
      bad++; $display("FAIL alternating: mean %0d ref %0d want 2812 1406", mean_abs, ref_level);
    end
  endtask

  task automatic test_most_negative();
    do_reset();
    run_strobes(15, 1'b1, 0, -131072);
    run_strobes(1, 1'b1, 0, -131072);
    total++;
    if (mean_abs !== 18'd122880 || ref_level !== 18'd61440) begin
      bad++; $display("FAIL most_negative: mean %0d ref %0d want 122880 61440", mean_abs, ref_level);
    end
  endtask

  task automatic test_short_period();
    do_reset();
    run_strobes(10, 1'b1, 0, 1000);
    run_strobes(1, 1'b1, 0, 1000);
    total++;
    if (mean_abs !== 18'd625 || period_err !== 1'b1) begin
      bad++; $display("FAIL short_period: mean %0d err %b want 625 1", mean_abs, period_err);
    end
    run_strobes(14, 1'b0, 0, 1000);
    run_strobes(15, 1'b1, 0, 1000);
    run_strobes(1, 1'b1, 0, 1000);
    total++;
    if (mean_abs !== 18'd937 || period_err !== 1'b1) begin
      bad++; $display("FAIL sticky_err: mean %0d err %b want 937 1", mean_abs, period_err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_strobes(15, 1'b1, 0, 2000);
    run_strobes(8, 1'b1, 2, 0);
    do_reset();
    total++;
    if (mean_abs !== 18'd0 || ref_locked !== 1'b0 || period_err !== 1'b0) begin
      bad++; $display("FAIL mid_reset: mean %0d locked %b err %b want 0 0 0", mean_abs, ref_locked, period_err);
    end
    run_strobes(5, 1'b0, 2, 0);
    run_strobes(15, 1'b1, 0, 1000);
    total++;
    if (mean_abs !== 18'd0 || ref_locked !== 1'b0) begin
      bad++; $display("FAIL one_marker: mean %0d locked %b want 0 0", mean_abs, ref_locked);
    end
    run_strobes(1, 1'b1, 0, 1000);
    total++;
    if (mean_abs !== 18'd937 || ref_locked !== 1'b1) begin
      bad++; $display("FAIL post_reset: mean %0d locked %b want 937 1", mean_abs, ref_locked);
    end
  endtask

  task automatic test_clk_en_gap();
    do_reset();
    run_strobes(8, 1'b1, 0, 1000);
    repeat (20) begin
      @(negedge clk);
      clk_en = 1'b0; cycle_start = 1'($urandom); sample_in = DATA_W'($urandom);
    end
    @(negedge clk);
    cycle_start = 1'b0;
    #1;
    total++;
    if (ref_valid !== 1'b0 || ref_locked !== 1'b0) begin
      bad++; $display("FAIL gap_no_close: valid %b locked %b want 0 0", ref_valid, ref_locked);
    end
    run_strobes(7, 1'b0, 0, 1000);
    run_strobes(1, 1'b1, 0, 1000);
    total++;
    if (mean_abs !== 18'd937 || ref_level !== 18'd468 || period_err !== 1'b0) begin
      bad++; $display("FAIL gap_result: mean %0d ref %0d err %b want 937 468 0", mean_abs, ref_level, period_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    run_strobes(15, 1'b1, 2, 0);
    for (int p = 0; p < 8; p++) begin
      run_strobes(($urandom_range(0, 3) == 0) ? $urandom_range(12, 18) : 15, 1'b1, 2, 0);
    end
    run_strobes(2, 1'b1, 2, 0);
  endtask

  initial begin
    test_reset();
    test_const_pos();
    test_alternating();
    test_most_negative();
    test_short_period();
    test_mid_reset();
    test_clk_en_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
